frame_border_restore: RTL and testbench

//  Downstream end of the bilateral3x3 output interface. Takes the raw gray stream and
//  the sparse filtered stream (interior pixels only, tagged with centre row/col). It
//  re-emits one dense, raster-ordered W x H frame: interior = filtered, border = raw.

---
 rtl/frame_border_restore.sv | 140 ++++++++++++++
 tb/tb_frame_border_restore.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_border_restore.sv
`default_nettype none
// ============================================================================
// frame_border_restore : merges the raw gray stream and the sparse filtered
// stream into one dense raster frame (interior = filtered, border = raw). Rev 1.0
// ============================================================================
module frame_border_restore #(
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 240,
    parameter int RAW_DEPTH    = 1024,
    parameter int FLT_DEPTH    = 4,
    parameter int ROW_W        = 12,
    parameter int COL_W        = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gray_valid,
    input  logic [7:0]       gray,
    input  logic             bilat_valid,
    input  logic [7:0]       bilat_out,
    input  logic [ROW_W-1:0] center_row,
    input  logic [COL_W-1:0] center_col,
    output logic             out_valid,
    output logic [7:0]       out_pix,
    output logic [ROW_W-1:0] out_row,
    output logic [COL_W-1:0] out_col,
    output logic             out_sof,
    output logic             out_eol,
    output logic             frame_done,
    output logic             raw_ovf,
    output logic             coord_err
);

    localparam int RA_W = $clog2(RAW_DEPTH);
    localparam int FA_W = $clog2(FLT_DEPTH);
    localparam int FE_W = ROW_W + COL_W + 8;
    localparam logic [ROW_W-1:0] c_last_row = ROW_W'(IMAGE_HEIGHT - 1);
    localparam logic [COL_W-1:0] c_last_col = COL_W'(IMAGE_WIDTH - 1);

    logic [7:0]      r_raw_mem [RAW_DEPTH];
    logic [RA_W-1:0] r_raw_wr, r_raw_rd;
    logic [RA_W:0]   r_raw_cnt;
    logic [FE_W-1:0] r_flt_mem [FLT_DEPTH];
    logic [FA_W-1:0] r_flt_wr, r_flt_rd;
    logic [FA_W:0]   r_flt_cnt;

    logic [ROW_W-1:0] r_orow;
    logic [COL_W-1:0] r_ocol;
    logic             r_done_pend;

    logic             w_raw_empty, w_raw_full, w_flt_empty, w_flt_full;
    logic             w_border, w_fire, w_raw_pop, w_flt_pop, w_raw_push, w_flt_push;
    logic             w_match, w_last_row, w_last_col;
    logic [FE_W-1:0]  w_flt_head;
    logic [7:0]       w_raw_head;

    always_comb begin
        w_raw_empty = (r_raw_cnt == '0);
        w_raw_full  = (r_raw_cnt == (RA_W+1)'(RAW_DEPTH));
        w_flt_empty = (r_flt_cnt == '0);
        w_flt_full  = (r_flt_cnt == (FA_W+1)'(FLT_DEPTH));
        w_last_row  = (r_orow == c_last_row);
        w_last_col  = (r_ocol == c_last_col);
        w_border    = (r_orow == '0) || w_last_row || (r_ocol == '0) || w_last_col;
        w_fire      = !w_raw_empty && (w_border || !w_flt_empty);
        w_raw_pop   = w_fire;
        w_flt_pop   = w_fire && !w_border;
        // A full FIFO still accepts a push in the cycle it is also popped.
        w_raw_push  = gray_valid && (!w_raw_full || w_raw_pop);
        w_flt_push  = bilat_valid && (!w_flt_full || w_flt_pop);
        w_raw_head  = r_raw_mem[r_raw_rd];
        w_flt_head  = r_flt_mem[r_flt_rd];
        w_match     = (w_flt_head[FE_W-1 -: ROW_W] == r_orow) &&
                      (w_flt_head[8 +: COL_W] == r_ocol);
    end

    always_ff @(posedge clk) begin
        if (w_raw_push) r_raw_mem[r_raw_wr] <= gray;
        if (w_flt_push) r_flt_mem[r_flt_wr] <= {center_row, center_col, bilat_out};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_raw_wr  <= '0;
            r_raw_rd  <= '0;
            r_raw_cnt <= '0;
            r_flt_wr  <= '0;
            r_flt_rd  <= '0;
            r_flt_cnt <= '0;
        end else begin
            if (w_raw_push) r_raw_wr <= r_raw_wr + RA_W'(1);
            if (w_raw_pop)  r_raw_rd <= r_raw_rd + RA_W'(1);
            if (w_raw_push && !w_raw_pop)      r_raw_cnt <= r_raw_cnt + (RA_W+1)'(1);
            else if (!w_raw_push && w_raw_pop) r_raw_cnt <= r_raw_cnt - (RA_W+1)'(1);
            if (w_flt_push) r_flt_wr <= r_flt_wr + FA_W'(1);
            if (w_flt_pop)  r_flt_rd <= r_flt_rd + FA_W'(1);
            if (w_flt_push && !w_flt_pop)      r_flt_cnt <= r_flt_cnt + (FA_W+1)'(1);
            else if (!w_flt_push && w_flt_pop) r_flt_cnt <= r_flt_cnt - (FA_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_orow      <= '0;
            r_ocol      <= '0;
            r_done_pend <= 1'b0;
            out_valid   <= 1'b0;
            out_pix     <= '0;
            out_row     <= '0;
            out_col     <= '0;
            out_sof     <= 1'b0;
            out_eol     <= 1'b0;
            frame_done  <= 1'b0;
            raw_ovf     <= 1'b0;
            coord_err   <= 1'b0;
        end else begin
            out_valid   <= w_fire;
            out_sof     <= w_fire && (r_orow == '0) && (r_ocol == '0);
            out_eol     <= w_fire && w_last_col;
            r_done_pend <= w_fire && w_last_row && w_last_col;
            frame_done  <= r_done_pend;
            raw_ovf     <= raw_ovf || (gray_valid && !w_raw_push);
            coord_err   <= coord_err || (bilat_valid && !w_flt_push) ||
                           (w_flt_pop && !w_match);
            if (w_fire) begin
                out_row <= r_orow;
                out_col <= r_ocol;
                // Mis-tagged filtered entries are discarded in favour of the raw pixel.
                out_pix <= (w_flt_pop && w_match) ? w_flt_head[7:0] : w_raw_head;
                if (w_last_col) begin
                    r_ocol <= '0;
                    r_orow <= w_last_row ? '0 : r_orow + ROW_W'(1);
                end else begin
                    r_ocol <= r_ocol + COL_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_border_restore.sv
`default_nettype none
// Testbench for frame_border_restore: scoreboarded raster checks on a 5x4 frame,
// plus a small-FIFO instance for the overflow case.
module tb_frame_border_restore;

    localparam int W = 5;
    localparam int H = 4;

    typedef struct packed {
        logic [11:0] row;
        logic [11:0] col;
        logic [7:0]  pix;
        logic        sof;
        logic        eol;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_a, gv_a, bv_a;
    logic [7:0]  g_a, b_a;
    logic [11:0] cr_a, cc_a;
    logic        ov_a, sof_a, eol_a, fd_a, ovf_a, cerr_a;
    logic [7:0]  op_a;
    logic [11:0] or_a, oc_a;

    logic        rst_n_b, gv_b, bv_b;
    logic [7:0]  g_b, b_b;
    logic [11:0] cr_b, cc_b;
    logic        ov_b, sof_b, eol_b, fd_b, ovf_b, cerr_b;
    logic [7:0]  op_b;
    logic [11:0] or_b, oc_b;

    frame_border_restore #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .RAW_DEPTH(32),
                           .FLT_DEPTH(4), .ROW_W(12), .COL_W(12)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .gray_valid(gv_a), .gray(g_a),
        .bilat_valid(bv_a), .bilat_out(b_a), .center_row(cr_a), .center_col(cc_a),
        .out_valid(ov_a), .out_pix(op_a), .out_row(or_a), .out_col(oc_a),
        .out_sof(sof_a), .out_eol(eol_a), .frame_done(fd_a),
        .raw_ovf(ovf_a), .coord_err(cerr_a));

    frame_border_restore #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .RAW_DEPTH(8),
                           .FLT_DEPTH(4), .ROW_W(12), .COL_W(12)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .gray_valid(gv_b), .gray(g_b),
        .bilat_valid(bv_b), .bilat_out(b_b), .center_row(cr_b), .center_col(cc_b),
        .out_valid(ov_b), .out_pix(op_b), .out_row(or_b), .out_col(oc_b),
        .out_sof(sof_b), .out_eol(eol_b), .frame_done(fd_b),
        .raw_ovf(ovf_b), .coord_err(cerr_b));

    int   checks = 0;
    int   errors = 0;
    int   outs_a = 0;
    int   done_a = 0;
    exp_t q_a[$];
    exp_t obs_b[$];

    always @(negedge clk) begin
        if (rst_n_a) begin
            if (fd_a) done_a++;
            if (ov_a) begin
                outs_a++;
                checks++;
                if (q_a.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out got (%0d,%0d)=%0d required no output",
                             or_a, oc_a, op_a);
                end else begin
                    exp_t e;
                    e = q_a.pop_front();
                    if ({or_a, oc_a, op_a, sof_a, eol_a} !== e)
                    begin
                        errors++;
                        $display("FAIL out_pixel got (%0d,%0d)=%0d sof=%0b eol=%0b required (%0d,%0d)=%0d sof=%0b eol=%0b",
                                 or_a, oc_a, op_a, sof_a, eol_a, e.row, e.col, e.pix, e.sof, e.eol);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n_b && ov_b) obs_b.push_back({or_b, oc_b, op_b, sof_b, eol_b});
    end

    task automatic idle_a();
        gv_a = 1'b0; g_a = '0; bv_a = 1'b0; b_a = '0; cr_a = '0; cc_a = '0;
    endtask

    // Drives one W x H frame: raw every gap+1 cycles, filtered for (r,c) 'delay'
    // cycles after raw (r+1,c+1) arrives, as the upstream 3x3 window would produce.
    task automatic run_frame(input int base, input int gap, input int delay, input bit bad_tag);
        int T;
        T = (W*H - 1) * (gap + 1) + delay + 1;
        for (int t = 0; t <= T; t++) begin
            idle_a();
            if ((t % (gap + 1)) == 0 && (t / (gap + 1)) < W*H) begin
                int i, r, c;
                bit inter, bad;
                i = t / (gap + 1); r = i / W; c = i % W;
                inter = (r >= 1 && r <= H-2 && c >= 1 && c <= W-2);
                bad = bad_tag && r == 1 && c == 1;
                gv_a = 1'b1;
                g_a = 8'(base + i);
                q_a.push_back({12'(r), 12'(c), (inter && !bad) ? 8'(base + i + 100) : 8'(base + i),
                               (i == 0), (c == W-1)});
            end
            for (int r = 1; r <= H-2; r++) begin
                for (int c = 1; c <= W-2; c++) begin
                    int k;
                    k = (r + 1) * W + c + 1;
                    if (k * (gap + 1) + delay == t) begin
                        bv_a = 1'b1;
                        b_a  = 8'(base + r*W + c + 100);
                        cr_a = 12'(r);
                        cc_a = (bad_tag && r == 1 && c == 1) ? 12'd2 : 12'(c);
                    end
                end
            end
            @(posedge clk); #1;
        end
        idle_a();
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q_a.size() != 0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (q_a.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout got %0d pending required 0", q_a.size());
            q_a.delete();
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset_a();
        rst_n_a = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n_a = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic check_frame(input string name, input int o0, input int d0,
                               input int n_out, input int n_done, input bit exp_cerr);
        checks++;
        if (outs_a - o0 !== n_out) begin
            errors++;
            $display("FAIL %s_count got %0d required %0d", name, outs_a - o0, n_out);
        end
        checks++;
        if (done_a - d0 !== n_done) begin
            errors++;
            $display("FAIL %s_frame_done got %0d required %0d", name, done_a - d0, n_done);
        end
        checks++;
        if ({ovf_a, cerr_a} !== {1'b0, exp_cerr}) begin
            errors++;
            $display("FAIL %s_flags got ovf=%0b cerr=%0b required ovf=0 cerr=%0b",
                     name, ovf_a, cerr_a, exp_cerr);
        end
    endtask

    task automatic test_reset();
        idle_a();
        gv_b = 1'b0; g_b = '0; bv_b = 1'b0; b_b = '0; cr_b = '0; cc_b = '0;
        rst_n_a = 1'b0; rst_n_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ov_a, op_a, or_a, oc_a, sof_a, eol_a, fd_a, ovf_a, cerr_a} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%0b pix=%0d row=%0d col=%0d flags=%0b%0b%0b%0b%0b required all 0",
                     ov_a, op_a, or_a, oc_a, sof_a, eol_a, fd_a, ovf_a, cerr_a);
        end
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_ramp();
        int o0, d0;
        o0 = outs_a; d0 = done_a;
        run_frame(0, 10, 0, 1'b0);
        wait_drain();
        check_frame("ramp", o0, d0, 20, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        int o0, d0;
        o0 = outs_a; d0 = done_a;
        run_frame(0, 0, W + 2, 1'b0);
        wait_drain();
        check_frame("b2b", o0, d0, 20, 1, 1'b0);
    endtask

    task automatic test_coord_mismatch();
        int o0, d0;
        o0 = outs_a; d0 = done_a;
        run_frame(0, 10, 0, 1'b1);
        wait_drain();
        check_frame("mismatch", o0, d0, 20, 1, 1'b1);
    endtask

    task automatic test_two_frames();
        int o0, d0;
        pulse_reset_a();
        o0 = outs_a; d0 = done_a;
        run_frame(0, 0, W + 2, 1'b0);
        run_frame(20, 0, W + 2, 1'b0);
        wait_drain();
        check_frame("two_frames", o0, d0, 40, 2, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        int o0, d0;
        o0 = outs_a; d0 = done_a;
        for (int i = 0; i < 7; i++) begin
            idle_a();
            gv_a = 1'b1;
            g_a  = 8'(i);
            if (i == 6) begin
                bv_a = 1'b1; b_a = 8'd106; cr_a = 12'd1; cc_a = 12'd1;
            end
            q_a.push_back({12'(i / W), 12'(i % W), (i == 6) ? 8'd106 : 8'(i), (i == 0), (i % W == W-1)});
            @(posedge clk); #1;
        end
        idle_a();
        wait_drain();
        check_frame("partial", o0, d0, 7, 0, 1'b0);
        rst_n_a = 1'b0;
        @(negedge clk);
        checks++;
        if ({ov_a, or_a, oc_a, fd_a} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got v=%0b row=%0d col=%0d done=%0b required all 0",
                     ov_a, or_a, oc_a, fd_a);
        end
        @(posedge clk); #1;
        rst_n_a = 1'b1;
        @(posedge clk); #1;
        o0 = outs_a; d0 = done_a;
        run_frame(0, 0, W + 2, 1'b0);
        wait_drain();
        check_frame("after_reset", o0, d0, 20, 1, 1'b0);
    endtask

    // Only border positions can drain with no filtered input, so the raw FIFO stalls
    // at (1,1); sixteen pushes are enough to overrun the 8 entries.
    task automatic test_raw_overflow();
        obs_b.delete();
        for (int i = 0; i < 16; i++) begin
            gv_b = 1'b1;
            g_b  = 8'(i);
            @(posedge clk); #1;
        end
        gv_b = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (obs_b.size() !== 6) begin
            errors++;
            $display("FAIL ovf_count got %0d required 6", obs_b.size());
        end
        for (int i = 0; i < 6 && i < obs_b.size(); i++) begin
            exp_t e;
            e = {12'(i / W), 12'(i % W), 8'(i), (i == 0), (i % W == W-1)};
            checks++;
            if (obs_b[i] !== e) begin
                errors++;
                $display("FAIL ovf_out%0d got (%0d,%0d)=%0d required (%0d,%0d)=%0d",
                         i, obs_b[i].row, obs_b[i].col, obs_b[i].pix, e.row, e.col, e.pix);
            end
        end
        checks++;
        if ({ovf_b, cerr_b, fd_b} !== 3'b100) begin
            errors++;
            $display("FAIL ovf_flags got ovf=%0b cerr=%0b done=%0b required ovf=1 cerr=0 done=0",
                     ovf_b, cerr_b, fd_b);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_back_to_back();
        test_coord_mismatch();
        test_two_frames();
        test_reset_mid_frame();
        test_raw_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
